// File: rtl/mem_crc_pkg.sv
// Shared types and parameter defaults for the memory CRC scrubber.
package mem_crc_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_POLYNOMIAL_BITS = 1;
  localparam int DEF_ADDR_WIDTH      = 8;
  localparam int DEF_POLY            = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/crc_gen.sv
// Combinational CRC over one data word: MSB-first, zero init, no reflection, no final XOR.
module crc_gen
  import mem_crc_pkg::*;
#(
  parameter int                         DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int                         POLYNOMIAL_BITS = DEF_POLYNOMIAL_BITS,
  parameter logic [POLYNOMIAL_BITS-1:0] POLY            = POLYNOMIAL_BITS'(DEF_POLY)
) (
  input  logic [DATA_WIDTH-1:0]      data,
  output logic [POLYNOMIAL_BITS-1:0] crc
);

  logic fb;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb  = crc[POLYNOMIAL_BITS-1] ^ data[i];
      crc = (crc << 1) ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/mem_crc_scrubber.sv
// Sweeps a memory, recomputes each word's CRC and reports mismatches.
// Optional macro MEM_CRC_SCRUB_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module mem_crc_scrubber
  import mem_crc_pkg::*;
#(
  parameter int                         DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int                         POLYNOMIAL_BITS = DEF_POLYNOMIAL_BITS,
  parameter int                         ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter logic [POLYNOMIAL_BITS-1:0] POLY            = POLYNOMIAL_BITS'(DEF_POLY)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  input  logic [POLYNOMIAL_BITS-1:0] rd_crc,
  output logic                       busy,
  output logic                       done,
  output logic                       err_valid,
  output logic [ADDR_WIDTH-1:0]      err_addr,
  output logic [ADDR_WIDTH:0]        err_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                     state, state_nxt;
  logic [ADDR_WIDTH-1:0]      scan_addr, scan_addr_nxt;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [POLYNOMIAL_BITS-1:0] crc_q;
  logic [POLYNOMIAL_BITS-1:0] crc_calc;
  logic                       mismatch;
  logic                       err_flag;
  logic                       clr_count;

  crc_gen #(
    .DATA_WIDTH      (DATA_WIDTH),
    .POLYNOMIAL_BITS (POLYNOMIAL_BITS),
    .POLY            (POLY)
  ) u_crc_gen (
    .data (data_q),
    .crc  (crc_calc)
  );

  assign mismatch = (crc_calc != crc_q);

  always_comb begin
    state_nxt     = state;
    scan_addr_nxt = scan_addr;
    err_flag      = 1'b0;
    clr_count     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt     = READ;
          scan_addr_nxt = '0;
          clr_count     = 1'b1;
        end
      end
      READ: state_nxt = stop ? IDLE : CHECK;
      CHECK: begin
        // An abort wins over reporting the word being checked.
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          err_flag = mismatch;
`ifdef MEM_CRC_SCRUB_STOP_ON_ERR_EN
          if (mismatch || scan_addr == LAST_ADDR) begin
`else
          if (scan_addr == LAST_ADDR) begin
`endif
            state_nxt = DONE;
          end else begin
            state_nxt     = READ;
            scan_addr_nxt = scan_addr + ADDR_WIDTH'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scan_addr <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      scan_addr <= scan_addr_nxt;
      err_valid <= err_flag;
      if (clr_count) begin
        err_count <= '0;
      end else if (err_flag) begin
        err_addr  <= scan_addr;
        err_count <= err_count + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // NOTE: capture registers carry no reset; READ always loads them before CHECK uses them.
  always_ff @(posedge clk) begin
    if (state == READ) begin
      data_q <= rd_data;
      crc_q  <= rd_crc;
    end
  end

  assign rd_addr = (state == IDLE) ? '0 : scan_addr;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE) && !stop;

endmodule

// File: tb/tb_mem_crc_scrubber.sv
// Scoreboard bench for mem_crc_scrubber: directed sweeps with expected events queued up front.
module tb_mem_crc_scrubber;

  localparam int AW  = 8;
  localparam int AW8 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, start8 = 1'b0, stop8 = 1'b0;

  always #5 clk = ~clk;

  // Default DUT with its memory model
  logic [AW-1:0] rd_addr, err_addr;
  logic [7:0]    rd_data;
  logic          rd_crc;
  logic          busy, done, err_valid;
  logic [AW:0]   err_count;
  logic [7:0]    mem  [256];
  logic          crcm [256];

  assign rd_data = mem[rd_addr];
  assign rd_crc  = crcm[rd_addr];

  mem_crc_scrubber dut (
    .clk (clk), .rst_n (rst_n), .start (start), .stop (stop),
    .rd_addr (rd_addr), .rd_data (rd_data), .rd_crc (rd_crc),
    .busy (busy), .done (done), .err_valid (err_valid),
    .err_addr (err_addr), .err_count (err_count)
  );

  // CRC-8 (poly 0x07) DUT over a 16-word memory
  logic [AW8-1:0] rd_addr8, err_addr8;
  logic [7:0]     rd_data8, rd_crc8;
  logic           busy8, done8, err_valid8;
  logic [AW8:0]   err_count8;
  logic [7:0]     mem8  [16];
  logic [7:0]     crcm8 [16];

  assign rd_data8 = mem8[rd_addr8];
  assign rd_crc8  = crcm8[rd_addr8];

  mem_crc_scrubber #(
    .DATA_WIDTH (8), .POLYNOMIAL_BITS (8), .ADDR_WIDTH (AW8), .POLY (8'h07)
  ) dut8 (
    .clk (clk), .rst_n (rst_n), .start (start8), .stop (stop8),
    .rd_addr (rd_addr8), .rd_data (rd_data8), .rd_crc (rd_crc8),
    .busy (busy8), .done (done8), .err_valid (err_valid8),
    .err_addr (err_addr8), .err_count (err_count8)
  );

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     addr;
    int     count;
    longint cycle;
  } ev_t;

  ev_t err_q[$], done_q[$], err_q8[$], done_q8[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input int addr, input int count, input longint cycle);
    ev_t e;
    e.addr  = addr;
    e.count = count;
    e.cycle = cycle;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    ev_t e;
    if (rst_n) begin
      if (err_valid) begin
        if (err_q.size() == 0) check("unexpected_err_valid", err_valid, 0);
        else begin
          e = err_q.pop_front();
          check("err_addr", err_addr, e.addr);
          check("err_count_at_err", err_count, e.count);
          check("err_cycle", cyc, e.cycle);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", done, 0);
        else begin
          e = done_q.pop_front();
          check("err_count_at_done", err_count, e.count);
          check("done_cycle", cyc, e.cycle);
        end
      end
    end
  end

  always @(negedge clk) begin : mon8
    ev_t e;
    if (rst_n) begin
      if (err_valid8) begin
        if (err_q8.size() == 0) check("unexpected_err_valid8", err_valid8, 0);
        else begin
          e = err_q8.pop_front();
          check("err_addr8", err_addr8, e.addr);
          check("err_count8_at_err", err_count8, e.count);
          check("err_cycle8", cyc, e.cycle);
        end
      end
      if (done8) begin
        if (done_q8.size() == 0) check("unexpected_done8", done8, 0);
        else begin
          e = done_q8.pop_front();
          check("err_count8_at_done", err_count8, e.count);
          check("done_cycle8", cyc, e.cycle);
        end
      end
    end
  end

  // Returns the cycle count seen just before the edge that samples start.
  task automatic pulse_start(output longint n);
    @(negedge clk);
    n     = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input longint target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check("sweep_finished", busy, 0);
  endtask

  initial begin
    longint n;

    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'hA5;
      crcm[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      mem8[i]  = 8'h01;
      crcm8[i] = 8'h07;
    end
    crcm8[4] = 8'h06;

    // Reset values
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_err_count", err_count, 0);
    check("rst_rd_addr", rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean memory: full sweep, no errors; a mid-sweep start is ignored
    pulse_start(n);
    done_q.push_back(mk(0, 0, n + 513));
    wait_until(n + 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(600);
    check("clean_err_count", err_count, 0);
    check("idle_rd_addr", rd_addr, 0);

    // Single parity error at 0x10
    crcm[16] = 1'b1;
    pulse_start(n);
    err_q.push_back(mk(16, 1, n + 35));
`ifdef MEM_CRC_SCRUB_STOP_ON_ERR_EN
    done_q.push_back(mk(0, 1, n + 35));
`else
    done_q.push_back(mk(0, 1, n + 513));
`endif
    wait_idle(600);
    check("single_err_addr", err_addr, 16);
    check("single_err_count", err_count, 1);

    // Stop in cycle 20 after an error at address 2
    crcm[2] = 1'b1;
    pulse_start(n);
    err_q.push_back(mk(2, 1, n + 7));
`ifdef MEM_CRC_SCRUB_STOP_ON_ERR_EN
    done_q.push_back(mk(0, 1, n + 7));
`endif
    wait_until(n + 20);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_rd_addr", rd_addr, 0);
    check("stop_err_count_kept", err_count, 1);
    repeat (5) @(negedge clk);

    // start together with stop is ignored
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_with_stop_busy", busy, 0);

    // Restart from address 0 with a cleared count
    pulse_start(n);
    check("restart_rd_addr", rd_addr, 0);
    check("restart_busy", busy, 1);
    check("restart_err_count", err_count, 0);
    err_q.push_back(mk(2, 1, n + 7));
`ifdef MEM_CRC_SCRUB_STOP_ON_ERR_EN
    done_q.push_back(mk(0, 1, n + 7));
`else
    err_q.push_back(mk(16, 2, n + 35));
    done_q.push_back(mk(0, 2, n + 513));
`endif
    wait_idle(600);

    // Reset while CHECK of erroring address 2 is in progress
    pulse_start(n);
    wait_until(n + 6);
    check("pre_reset_rd_addr", rd_addr, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err_valid", err_valid, 0);
    check("mid_rst_err_addr", err_addr, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_err_count", err_count, 0);

    // CRC-8 poly 0x07: only address 4 mismatches
    @(negedge clk);
    n      = cyc;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    err_q8.push_back(mk(4, 1, n + 11));
`ifdef MEM_CRC_SCRUB_STOP_ON_ERR_EN
    done_q8.push_back(mk(0, 1, n + 11));
`else
    done_q8.push_back(mk(0, 1, n + 33));
`endif
    for (int i = 0; i < 100 && busy8; i++) @(negedge clk);
    check("crc8_sweep_finished", busy8, 0);
    check("crc8_err_addr", err_addr8, 4);
    check("crc8_err_count", err_count8, 1);

`ifdef MEM_CRC_SCRUB_STOP_ON_ERR_EN
    // Errors at 5 and 9: sweep ends at the first one
    for (int i = 0; i < 256; i++) crcm[i] = 1'b0;
    crcm[5] = 1'b1;
    crcm[9] = 1'b1;
    pulse_start(n);
    err_q.push_back(mk(5, 1, n + 13));
    done_q.push_back(mk(0, 1, n + 13));
    wait_idle(600);
    check("soe_err_addr", err_addr, 5);
    check("soe_err_count", err_count, 1);
`endif

    repeat (5) @(negedge clk);
    check("pending_err_events", err_q.size(), 0);
    check("pending_done_events", done_q.size(), 0);
    check("pending_err_events8", err_q8.size(), 0);
    check("pending_done_events8", done_q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
